// File: rtl/alu_ctrl_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_ctrl_encoder                                              |
// | Brief    : ID-stage MIPS decode to ALU control code, registered into     |
// |            ID/EX with stall/flush, valid, illegal flag and counter.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alu_ctrl_encoder #(
  parameter int ILL_CNT_W    = 8,
  parameter bit VAR_SHIFT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          id_instr,
  input  logic                 id_valid,
  input  logic                 stall,
  input  logic                 flush,
  output logic [3:0]           ex_alu_ctrl,
  output logic                 ex_src_b_imm,
  output logic                 ex_imm_sext,
  output logic [1:0]           ex_shamt_sel,
  output logic [4:0]           ex_shamt,
  output logic                 ex_valid,
  output logic                 ex_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [3:0] c_alu_add  = 4'b0000;
  localparam logic [3:0] c_alu_sub  = 4'b0001;
  localparam logic [3:0] c_alu_and  = 4'b0010;
  localparam logic [3:0] c_alu_or   = 4'b0011;
  localparam logic [3:0] c_alu_xor  = 4'b0100;
  localparam logic [3:0] c_alu_nor  = 4'b0101;
  localparam logic [3:0] c_alu_sll  = 4'b0110;
  localparam logic [3:0] c_alu_srl  = 4'b0111;
  localparam logic [3:0] c_alu_sra  = 4'b1000;
  localparam logic [3:0] c_alu_sltu = 4'b1001;
  localparam logic [3:0] c_alu_slt  = 4'b1010;

  localparam logic [1:0] c_sel_field = 2'b00;
  localparam logic [1:0] c_sel_rs    = 2'b01;
  localparam logic [1:0] c_sel_16    = 2'b10;

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic [3:0] w_ctrl;
  logic       w_src_b_imm;
  logic       w_imm_sext;
  logic [1:0] w_shamt_sel;
  logic [4:0] w_shamt;
  logic       w_illegal;
  logic       w_unused_bits;

  logic [3:0]           r_alu_ctrl;
  logic                 r_src_b_imm;
  logic                 r_imm_sext;
  logic [1:0]           r_shamt_sel;
  logic [4:0]           r_shamt;
  logic                 r_valid;
  logic                 r_illegal;
  logic [ILL_CNT_W-1:0] r_ill_count;

  assign w_opcode      = id_instr[31:26];
  assign w_funct       = id_instr[5:0];
  assign w_unused_bits = ^id_instr[25:11];

  // Unrecognised encodings fall through with every field still at its zero default.
  always_comb begin
    w_ctrl      = c_alu_add;
    w_src_b_imm = 1'b0;
    w_imm_sext  = 1'b0;
    w_shamt_sel = c_sel_field;
    w_illegal   = 1'b0;
    case (w_opcode)
      6'b000000: begin
        case (w_funct)
          6'b100000, 6'b100001,
          6'b001000, 6'b001001: w_ctrl = c_alu_add;
          6'b100010, 6'b100011: w_ctrl = c_alu_sub;
          6'b100100:            w_ctrl = c_alu_and;
          6'b100101:            w_ctrl = c_alu_or;
          6'b100110:            w_ctrl = c_alu_xor;
          6'b100111:            w_ctrl = c_alu_nor;
          6'b000000:            w_ctrl = c_alu_sll;
          6'b000010:            w_ctrl = c_alu_srl;
          6'b000011:            w_ctrl = c_alu_sra;
          6'b101010:            w_ctrl = c_alu_slt;
          6'b101011:            w_ctrl = c_alu_sltu;
          6'b000100, 6'b000110, 6'b000111: begin
            if (VAR_SHIFT_EN) begin
              w_shamt_sel = c_sel_rs;
              case (w_funct[1:0])
                2'b00:   w_ctrl = c_alu_sll;
                2'b10:   w_ctrl = c_alu_srl;
                default: w_ctrl = c_alu_sra;
              endcase
            end else begin
              w_illegal = 1'b1;
            end
          end
          default: w_illegal = 1'b1;
        endcase
      end
      6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
        w_src_b_imm = 1'b1;
        w_imm_sext  = 1'b1;
      end
      6'b001010: begin
        w_ctrl      = c_alu_slt;
        w_src_b_imm = 1'b1;
        w_imm_sext  = 1'b1;
      end
      6'b001011: begin
        w_ctrl      = c_alu_sltu;
        w_src_b_imm = 1'b1;
        w_imm_sext  = 1'b1;
      end
      6'b001100: begin
        w_ctrl      = c_alu_and;
        w_src_b_imm = 1'b1;
      end
      6'b001101: begin
        w_ctrl      = c_alu_or;
        w_src_b_imm = 1'b1;
      end
      6'b001110: begin
        w_ctrl      = c_alu_xor;
        w_src_b_imm = 1'b1;
      end
      6'b001111: begin
        w_ctrl      = c_alu_sll;
        w_src_b_imm = 1'b1;
        w_shamt_sel = c_sel_16;
      end
      6'b000100, 6'b000101: w_ctrl = c_alu_sub;
      6'b000010, 6'b000011: w_ctrl = c_alu_add;
      default:              w_illegal = 1'b1;
    endcase
  end

  assign w_shamt = w_illegal ? 5'd0 : id_instr[10:6];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_alu_ctrl  <= 4'd0;
      r_src_b_imm <= 1'b0;
      r_imm_sext  <= 1'b0;
      r_shamt_sel <= 2'd0;
      r_shamt     <= 5'd0;
      r_valid     <= 1'b0;
      r_illegal   <= 1'b0;
      r_ill_count <= '0;
    end else if (flush) begin
      r_alu_ctrl  <= 4'd0;
      r_src_b_imm <= 1'b0;
      r_imm_sext  <= 1'b0;
      r_shamt_sel <= 2'd0;
      r_shamt     <= 5'd0;
      r_valid     <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!stall) begin
      r_alu_ctrl  <= w_ctrl;
      r_src_b_imm <= w_src_b_imm;
      r_imm_sext  <= w_imm_sext;
      r_shamt_sel <= w_shamt_sel;
      r_shamt     <= w_shamt;
      r_valid     <= id_valid;
      r_illegal   <= w_illegal & id_valid;
      // Saturate rather than wrap so a burst of junk never reads back as small.
      if (id_valid && w_illegal && (r_ill_count != '1)) begin
        r_ill_count <= r_ill_count + ILL_CNT_W'(1);
      end
    end
  end

  assign ex_alu_ctrl  = r_alu_ctrl;
  assign ex_src_b_imm = r_src_b_imm;
  assign ex_imm_sext  = r_imm_sext;
  assign ex_shamt_sel = r_shamt_sel;
  assign ex_shamt     = r_shamt;
  assign ex_valid     = r_valid;
  assign ex_illegal   = r_illegal;
  assign ill_count    = r_ill_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_ctrl_encoder                                           |
// | Brief    : Table-driven reference bench for alu_ctrl_encoder, two        |
// |            parameterisations driven from shared inputs.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_alu_ctrl_encoder;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       imm;
    logic       sext;
    logic [1:0] sel;
    logic [4:0] shamt;
    logic       valid;
    logic       ill;
    logic [7:0] cnt;
  } ex_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] id_instr = 32'd0;
  logic        id_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic [3:0] a_ctrl, b_ctrl;
  logic       a_imm, b_imm, a_sext, b_sext, a_valid, b_valid, a_ill, b_ill;
  logic [1:0] a_sel, b_sel;
  logic [4:0] a_shamt, b_shamt;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  ex_t obs_a, obs_b, exp_a, exp_b;
  int  nvec = 0;
  int  nerr = 0;

  int r_code[64];
  bit r_var[64];
  int i_code[64];
  bit i_imm[64];
  bit i_sext[64];
  bit i_lui[64];

  always #5 clk = ~clk;

  alu_ctrl_encoder #(.ILL_CNT_W(8), .VAR_SHIFT_EN(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
    .stall(stall), .flush(flush), .ex_alu_ctrl(a_ctrl), .ex_src_b_imm(a_imm),
    .ex_imm_sext(a_sext), .ex_shamt_sel(a_sel), .ex_shamt(a_shamt),
    .ex_valid(a_valid), .ex_illegal(a_ill), .ill_count(a_cnt)
  );

  alu_ctrl_encoder #(.ILL_CNT_W(2), .VAR_SHIFT_EN(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
    .stall(stall), .flush(flush), .ex_alu_ctrl(b_ctrl), .ex_src_b_imm(b_imm),
    .ex_imm_sext(b_sext), .ex_shamt_sel(b_sel), .ex_shamt(b_shamt),
    .ex_valid(b_valid), .ex_illegal(b_ill), .ill_count(b_cnt)
  );

  assign obs_a = {a_ctrl, a_imm, a_sext, a_sel, a_shamt, a_valid, a_ill, a_cnt};
  assign obs_b = {b_ctrl, b_imm, b_sext, b_sel, b_shamt, b_valid, b_ill, 6'd0, b_cnt};

  task automatic init_tables();
    for (int k = 0; k < 64; k++) begin
      r_code[k] = -1; r_var[k] = 0;
      i_code[k] = -1; i_imm[k] = 0; i_sext[k] = 0; i_lui[k] = 0;
    end
    r_code['h20] = 0; r_code['h21] = 0; r_code['h22] = 1; r_code['h23] = 1;
    r_code['h24] = 2; r_code['h25] = 3; r_code['h26] = 4; r_code['h27] = 5;
    r_code['h00] = 6; r_code['h02] = 7; r_code['h03] = 8;
    r_code['h04] = 6; r_code['h06] = 7; r_code['h07] = 8;
    r_var['h04] = 1;  r_var['h06] = 1;  r_var['h07] = 1;
    r_code['h2a] = 10; r_code['h2b] = 9; r_code['h08] = 0; r_code['h09] = 0;
    foreach (i_code[k]) begin
      if (k == 'h08 || k == 'h09 || k == 'h23 || k == 'h2b) begin
        i_code[k] = 0; i_imm[k] = 1; i_sext[k] = 1;
      end
    end
    i_code['h0a] = 10; i_imm['h0a] = 1; i_sext['h0a] = 1;
    i_code['h0b] = 9;  i_imm['h0b] = 1; i_sext['h0b] = 1;
    i_code['h0c] = 2;  i_imm['h0c] = 1;
    i_code['h0d] = 3;  i_imm['h0d] = 1;
    i_code['h0e] = 4;  i_imm['h0e] = 1;
    i_code['h0f] = 6;  i_imm['h0f] = 1; i_lui['h0f] = 1;
    i_code['h04] = 1;  i_code['h05] = 1;
    i_code['h02] = 0;  i_code['h03] = 0;
  endtask

  function automatic ex_t decode(logic [31:0] ins, bit var_en);
    ex_t d = '0;
    int  op = int'(ins[31:26]);
    int  fn = int'(ins[5:0]);
    if (op == 0) begin
      if (r_code[fn] < 0 || (r_var[fn] && !var_en)) d.ill = 1'b1;
      else begin
        d.ctrl = 4'(r_code[fn]);
        d.sel  = r_var[fn] ? 2'b01 : 2'b00;
      end
    end else if (i_code[op] < 0) begin
      d.ill = 1'b1;
    end else begin
      d.ctrl = 4'(i_code[op]);
      d.imm  = i_imm[op];
      d.sext = i_sext[op];
      d.sel  = i_lui[op] ? 2'b10 : 2'b00;
    end
    if (!d.ill) d.shamt = ins[10:6];
    return d;
  endfunction

  function automatic ex_t model_step(ex_t m, bit var_en, int cmax, logic rn, logic fl,
                                     logic st, logic v, logic [31:0] ins);
    ex_t n = m;
    ex_t d;
    if (!rn) n = '0;
    else if (fl) begin
      n = '0;
      n.cnt = m.cnt;
    end else if (!st) begin
      d = decode(ins, var_en);
      n = d;
      n.valid = v;
      n.ill = d.ill & v;
      n.cnt = m.cnt;
      if (v && d.ill && int'(m.cnt) < cmax) n.cnt = m.cnt + 8'd1;
    end
    return n;
  endfunction

  task automatic cycle(input logic rn, input logic fl, input logic st, input logic v,
                       input logic [31:0] ins);
    reset_n = rn; flush = fl; stall = st; id_valid = v; id_instr = ins;
    @(posedge clk);
    exp_a = model_step(exp_a, 1'b1, 255, rn, fl, st, v, ins);
    exp_b = model_step(exp_b, 1'b0, 3, rn, fl, st, v, ins);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    nvec++;
    if (obs_a !== 23'd0) begin nerr++; $display("FAIL reset_a: got %h want 0", obs_a); end
    nvec++;
    if (obs_b !== 23'd0) begin nerr++; $display("FAIL reset_b: got %h want 0", obs_b); end
  endtask

  task automatic test_add();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h00851020);
    nvec++;
    if ({a_ctrl, a_imm, a_valid, a_ill} !== {4'b0000, 1'b0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL add: got %h want 000_0_1_0", {a_ctrl, a_imm, a_valid, a_ill});
    end
    nvec++;
    if (obs_a !== exp_a) begin nerr++; $display("FAIL add_model: got %h want %h", obs_a, exp_a); end
  endtask

  task automatic test_lui_sra();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h3C01ABCD);
    nvec++;
    if ({a_ctrl, a_imm, a_sext, a_sel} !== {4'b0110, 1'b1, 1'b0, 2'b10}) begin
      nerr++; $display("FAIL lui: got %h want %h", {a_ctrl, a_imm, a_sext, a_sel}, {4'b0110, 1'b1, 1'b0, 2'b10});
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h000210C3);
    nvec++;
    if ({a_ctrl, a_sel, a_shamt} !== {4'b1000, 2'b00, 5'd3}) begin
      nerr++; $display("FAIL sra: got %h want %h", {a_ctrl, a_sel, a_shamt}, {4'b1000, 2'b00, 5'd3});
    end
    nvec++;
    if (obs_b !== exp_b) begin nerr++; $display("FAIL sra_model_b: got %h want %h", obs_b, exp_b); end
  endtask

  task automatic test_stall_flush();
    ex_t snap;
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h2841FFFF);
    nvec++;
    if ({a_ctrl, a_imm, a_sext} !== {4'b1010, 1'b1, 1'b1}) begin
      nerr++; $display("FAIL slti: got %h want %h", {a_ctrl, a_imm, a_sext}, {4'b1010, 1'b1, 1'b1});
    end
    snap = obs_a;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b1, $urandom);
      nvec++;
      if (obs_a !== snap) begin nerr++; $display("FAIL stall_hold: got %h want %h", obs_a, snap); end
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h00851020);
    nvec++;
    if ({a_valid, a_ctrl, a_imm, a_sext} !== 7'd0) begin
      nerr++; $display("FAIL flush_over_stall: got %h want 0", {a_valid, a_ctrl, a_imm, a_sext});
    end
    nvec++;
    if (obs_a !== exp_a) begin nerr++; $display("FAIL flush_model: got %h want %h", obs_a, exp_a); end
  endtask

  task automatic test_illegal();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hFC000000);
    nvec++;
    if ({a_ill, a_valid, a_cnt, b_cnt} !== {1'b1, 1'b1, 8'd1, 2'd1}) begin
      nerr++; $display("FAIL illegal_valid: got %h want %h", {a_ill, a_valid, a_cnt, b_cnt}, {1'b1, 1'b1, 8'd1, 2'd1});
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hFC000000);
    nvec++;
    if ({a_ill, a_valid, a_cnt} !== {1'b0, 1'b0, 8'd1}) begin
      nerr++; $display("FAIL illegal_invalid: got %h want %h", {a_ill, a_valid, a_cnt}, {1'b0, 1'b0, 8'd1});
    end
  endtask

  task automatic test_var_shift();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h00A21004);
    nvec++;
    if ({a_ctrl, a_sel, a_ill} !== {4'b0110, 2'b01, 1'b0}) begin
      nerr++; $display("FAIL sllv_enabled: got %h want %h", {a_ctrl, a_sel, a_ill}, {4'b0110, 2'b01, 1'b0});
    end
    nvec++;
    if ({b_ill, b_ctrl, b_sel} !== {1'b1, 4'b0000, 2'b00}) begin
      nerr++; $display("FAIL sllv_disabled: got %h want %h", {b_ill, b_ctrl, b_sel}, {1'b1, 4'b0000, 2'b00});
    end
  endtask

  task automatic test_saturate();
    int want;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hFC000000);
      want = (k > 3) ? 3 : k;
      nvec++;
      if (b_cnt !== 2'(want) || a_cnt !== 8'(k)) begin
        nerr++; $display("FAIL saturate_%0d: got b=%0d a=%0d want b=%0d a=%0d", k, b_cnt, a_cnt, want, k);
      end
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h00851020);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h00851020);
    nvec++;
    if (obs_a !== 23'd0 || obs_b !== 23'd0) begin
      nerr++; $display("FAIL reset_mid_stall: got a=%h b=%h want 0", obs_a, obs_b);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int k = 0; k < 400; k++) begin
      ins = $urandom;
      if ($urandom_range(1, 0) == 0) ins[31:26] = 6'd0;
      cycle(($urandom_range(39, 0) != 0), ($urandom_range(7, 0) == 0),
            ($urandom_range(4, 0) == 0), ($urandom_range(3, 0) != 0), ins);
      nvec++;
      if (obs_a !== exp_a) begin nerr++; $display("FAIL random_a[%0d]: got %h want %h", k, obs_a, exp_a); end
      nvec++;
      if (obs_b !== exp_b) begin nerr++; $display("FAIL random_b[%0d]: got %h want %h", k, obs_b, exp_b); end
    end
  endtask

  initial begin
    exp_a = '0;
    exp_b = '0;
    init_tables();
    test_reset();
    test_add();
    test_lui_sra();
    test_stall_flush();
    test_illegal();
    test_var_shift();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_encoder.md
Name: alu_ctrl_encoder

Overview:
- ID-stage encoder that turns a fetched MIPS instruction into the 4-bit ALU control code consumed by the EX-stage ALU controller, plus operand-select side info.
- Results are registered into the ID/EX pipeline register with stall/flush handling, a valid bit, an illegal-instruction flag and a saturating illegal counter.
- Sits between the instruction decode path and the EX-stage ALU.

Parameters:
- ILL_CNT_W, 8: width of the saturating illegal-instruction counter.
- VAR_SHIFT_EN, 1: when 1, sllv/srlv/srav are legal; when 0 they decode as illegal.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset, sampled on rising clk.
- id_instr  input  32  instruction in ID.
- id_valid  input  1  id_instr holds a real instruction.
- stall  input  1  hold ID/EX contents.
- flush  input  1  insert bubble into ID/EX.
- ex_alu_ctrl  output  4  registered ALU control code.
- ex_src_b_imm  output  1  ALU operand B comes from the immediate.
- ex_imm_sext  output  1  immediate is sign-extended; 0 means zero-extended.
- ex_shamt_sel  output  2  shift amount source: 00 = shamt field, 01 = rs[4:0], 10 = constant 16.
- ex_shamt  output  5  captured instr[10:6].
- ex_valid  output  1  EX slot holds a real instruction.
- ex_illegal  output  1  EX instruction is unrecognised.
- ill_count  output  ILL_CNT_W  saturating count of illegal instructions loaded.

Behaviour:
- Codes: add 0000, sub 0001, and 0010, or 0011, xor 0100, nor 0101, sll 0110, srl 0111, sra 1000, sltu 1001, slt 1010.
- R-type (opcode 000000), decoded by funct:
  - 100000/100001 -> 0000; 100010/100011 -> 0001.
  - 100100 -> 0010; 100101 -> 0011; 100110 -> 0100; 100111 -> 0101.
  - 000000/000010/000011 -> 0110/0111/1000 with shamt_sel 00.
  - 000100/000110/000111 -> 0110/0111/1000 with shamt_sel 01.
  - 101010 -> 1010; 101011 -> 1001.
  - 001000 (jr) and 001001 (jalr) -> 0000, legal.
  - All R-type: src_b_imm 0.
- I-type and other opcodes:
  - addi 001000, addiu 001001, lw 100011, sw 101011 -> 0000, imm, sext.
  - slti 001010 -> 1010, imm, sext; sltiu 001011 -> 1001, imm, sext.
  - andi 001100 -> 0010, ori 001101 -> 0011, xori 001110 -> 0100; all imm, zero-ext.
  - lui 001111 -> 0110, imm, zero-ext, shamt_sel 10.
  - beq 000100, bne 000101 -> 0001, src_b_imm 0.
  - j 000010, jal 000011 -> 0000, legal.
- Defaults: for any decoded instruction, fields not listed above are 0.
- Illegal instruction (anything else, or a variable shift with VAR_SHIFT_EN=0): ctrl 0000, every other field 0, illegal 1.
- Latency: one cycle. Outputs reflect the id_instr sampled at the previous rising edge.
- Per-edge priority:
  - reset_n=0: every output register and ill_count go to 0.
  - else flush=1: bubble, with all fields 0 and ex_valid 0. Flush wins over stall.
  - else stall=1: hold every output register unchanged.
  - else load: the decoded fields, ex_valid=id_valid, ex_illegal=illegal&id_valid.
- id_valid=0 on load: fields decoded as usual, but ex_valid 0 and ex_illegal 0.
- ill_count:
  - Increments by 1 only on a load with id_valid=1 and illegal=1.
  - Saturates at all-ones; it does not wrap.
  - Unaffected by flush/stall and cleared only by reset.
- Reset mid-stall: reset wins; the held contents are lost.
- Decode logic is purely combinational from id_instr. No state other than the output registers and ill_count.

Test Plan:
- Reset, then load id_instr=0x00851020 (add $2,$4,$5), id_valid=1 -> next cycle ex_alu_ctrl=0000, src_b_imm=0, ex_valid=1, ex_illegal=0.
- Load 0x3C01ABCD (lui) -> ctrl 0110, src_b_imm=1, imm_sext=0, shamt_sel=10. Then load 0x000210C3 (sra $2,$2,3) -> ctrl 1000, shamt_sel=00, ex_shamt=3.
- Load slti 0x2841FFFF -> ctrl 1010, imm_sext=1. Assert stall for 3 cycles while id_instr changes -> outputs stay frozen. Assert stall+flush together -> bubble: ex_valid 0, ctrl 0000.
- Load 0xFC000000 (opcode 111111), id_valid=1 -> ex_illegal=1, ill_count 0->1. Same word with id_valid=0 -> ex_illegal=0, count unchanged.
- VAR_SHIFT_EN=0: sllv 0x00A21004 -> ex_illegal=1. VAR_SHIFT_EN=1: same word -> ctrl 0110, shamt_sel=01.
- ILL_CNT_W=2: 5 illegal loads -> ill_count reaches 3 and holds. Then reset_n=0 for one edge -> every output and ill_count return to 0.
